// File: rtl/gpio_bank_if.sv
// Peripheral bus seen by gpio_bank: word-addressed write and read channels,
// read data is a shared tri-state line.
interface gpio_bank_if;
  logic [31:0] sys_w_addr;
  logic [31:0] sys_r_addr;
  logic [31:0] sys_w_line;
  logic [31:0] sys_r_line;
  logic        sys_w;
  logic        sys_r;

  modport master (output sys_w_addr, sys_r_addr, sys_w_line, sys_w, sys_r,
                  input  sys_r_line);
  modport slave  (input  sys_w_addr, sys_r_addr, sys_w_line, sys_w, sys_r,
                  output sys_r_line);
endinterface

// File: rtl/gpio_bank.sv
// Bank of N_PORTS 32-pin GPIO ports: per-port OUT/DIR/IN/edge-enable/ISR
// registers behind a word-addressed window, synchronised inputs, level irq.
module gpio_port #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pin_in,
  input  logic        wr_en,
  input  logic [2:0]  wr_off,
  input  logic [31:0] wr_data,
  input  logic [2:0]  rd_off,
  output logic [31:0] rd_data,
  output logic [31:0] out_q,
  output logic [31:0] dir_q,
  output logic        irq
);
  logic [SYNC_STAGES-1:0][31:0] sync_q;
  logic [31:0] in_q, prev_q, rise_en_q, fall_en_q, isr_q;
  logic [31:0] edge_hit, w1c_mask;

  assign in_q     = sync_q[SYNC_STAGES-1];
  assign edge_hit = (in_q & ~prev_q & rise_en_q) | (~in_q & prev_q & fall_en_q);
  assign w1c_mask = (wr_en && wr_off == 3'd5) ? wr_data : 32'h0;
  assign irq      = |isr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      prev_q    <= '0;
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      isr_q     <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= in_q;
      // a fresh edge in the same cycle as a W1C keeps the bit set
      isr_q  <= (isr_q & ~w1c_mask) | edge_hit;
      if (wr_en) begin
        case (wr_off)
          3'd0:    out_q     <= wr_data;
          3'd1:    dir_q     <= wr_data;
          3'd3:    rise_en_q <= wr_data;
          3'd4:    fall_en_q <= wr_data;
          3'd6:    out_q     <= out_q | wr_data;
          3'd7:    out_q     <= out_q & ~wr_data;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = 32'h0;
    case (rd_off)
      3'd0:    rd_data = out_q;
      3'd1:    rd_data = dir_q;
      3'd2:    rd_data = in_q;
      3'd3:    rd_data = rise_en_q;
      3'd4:    rd_data = fall_en_q;
      3'd5:    rd_data = isr_q;
      default: rd_data = 32'h0;
    endcase
  end
endmodule

module gpio_bank #(
  parameter int          N_PORTS     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0A,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  inout  wire [32*N_PORTS-1:0] pins,
  gpio_bank_if.slave         bus,
  output logic [N_PORTS-1:0] irq
);
  localparam int          IW  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [31:0] WIN = 32'(8 * N_PORTS);

  logic [31:0] w_off, r_off;
  logic        w_hit, r_hit;
  logic [N_PORTS-1:0][31:0] out_q, dir_q, rd_data;

  assign w_off = bus.sys_w_addr - BASE_ADDR;
  assign r_off = bus.sys_r_addr - BASE_ADDR;
  assign w_hit = bus.sys_w && (bus.sys_w_addr >= BASE_ADDR) && (w_off < WIN);
  assign r_hit = bus.sys_r && (bus.sys_r_addr >= BASE_ADDR) && (r_off < WIN);

  generate
    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
      gpio_port #(.SYNC_STAGES(SYNC_STAGES)) u_port (
        .clk     (clk),
        .rst     (rst),
        .pin_in  (pins[32*p +: 32]),
        .wr_en   (w_hit && (w_off[IW+2:3] == IW'(p))),
        .wr_off  (w_off[2:0]),
        .wr_data (bus.sys_w_line),
        .rd_off  (r_off[2:0]),
        .rd_data (rd_data[p]),
        .out_q   (out_q[p]),
        .dir_q   (dir_q[p]),
        .irq     (irq[p])
      );
      // driven pins also loop back into the synchroniser through pin_in
      for (genvar b = 0; b < 32; b++) begin : g_pin
        assign pins[32*p+b] = dir_q[p][b] ? out_q[p][b] : 1'bz;
      end
    end
  endgenerate

  assign bus.sys_r_line = r_hit ? rd_data[r_off[IW+2:3]] : 32'bz;
endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank (N_PORTS=4, BASE_ADDR=0x0A, SYNC_STAGES=2):
// register table vectors, then edge/ISR, loopback and reset sequences.
module tb_gpio_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0]   irq;
  wire  [127:0] pins;
  logic [127:0] tb_en, tb_val;
  int errors = 0;
  int checks = 0;

  gpio_bank_if bif();

  gpio_bank #(.N_PORTS(4), .BASE_ADDR(32'h0A), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .pins (pins),
    .bus  (bif),
    .irq  (irq)
  );

  for (genvar i = 0; i < 128; i++) begin : g_drv
    assign pins[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
    bit          expz;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // undriven bus reads z in a 4-state simulator and 0 in a 2-state one
  task automatic chk_z(input string name, input logic [31:0] act);
    checks++;
    if (!(act === 32'bz || act === 32'h0)) begin
      errors++;
      $display("FAIL %s: got %h expected z", name, act);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bif.sys_r_addr = a;
    bif.sys_r      = 1'b1;
    #1;
    v = bif.sys_r_line;
    bif.sys_r = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(name, v, exp);
  endtask

  // called at posedge+1, returns at posedge+1 after the write edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bif.sys_w_addr = a;
    bif.sys_w_line = d;
    bif.sys_w      = 1'b1;
    @(posedge clk); #1;
    bif.sys_w = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [31:0] v;
    vecs[0]  = '{1'b1, 32'h0B, 32'h0000_00FF, 32'h0B, 32'h0000_00FF, 1'b0, "dir_wr"};
    vecs[1]  = '{1'b1, 32'h0A, 32'h0000_00A5, 32'h0A, 32'h0000_00A5, 1'b0, "out_wr"};
    vecs[2]  = '{1'b1, 32'h10, 32'h0000_0100, 32'h0A, 32'h0000_01A5, 1'b0, "set"};
    vecs[3]  = '{1'b1, 32'h11, 32'h0000_0001, 32'h0A, 32'h0000_01A4, 1'b0, "clr"};
    vecs[4]  = '{1'b0, 32'h00, 32'h0,         32'h10, 32'h0,         1'b0, "set_rd0"};
    vecs[5]  = '{1'b0, 32'h00, 32'h0,         32'h11, 32'h0,         1'b0, "clr_rd0"};
    vecs[6]  = '{1'b0, 32'h00, 32'h0,         32'h0B, 32'h0000_00FF, 1'b0, "dir_keep"};
    vecs[7]  = '{1'b1, 32'h2A, 32'h0000_FFFF, 32'h0A, 32'h0000_01A4, 1'b0, "oow_wr"};
    vecs[8]  = '{1'b0, 32'h00, 32'h0,         32'h22, 32'h0,         1'b0, "p3_out"};
    vecs[9]  = '{1'b1, 32'h0C, 32'hFFFF_FFFF, 32'h0C, 32'h0000_00A4, 1'b0, "in_ro"};
    vecs[10] = '{1'b1, 32'h12, 32'h1234_5678, 32'h12, 32'h1234_5678, 1'b0, "p1_out"};
    vecs[11] = '{1'b1, 32'h15, 32'h0000_0001, 32'h15, 32'h0000_0001, 1'b0, "rise_en"};
    vecs[12] = '{1'b1, 32'h16, 32'h0000_0002, 32'h16, 32'h0000_0002, 1'b0, "fall_en"};
    vecs[13] = '{1'b0, 32'h00, 32'h0,         32'h09, 32'h0,         1'b1, "below_win"};
    vecs[14] = '{1'b0, 32'h00, 32'h0,         32'h2A, 32'h0,         1'b1, "above_win"};
    vecs[15] = '{1'b1, 32'h0F, 32'h0000_0005, 32'h0F, 32'h0,         1'b0, "isr_w1c0"};

    // tb drives every pin except port0 bits 7:0, which the DUT will own
    tb_en  = {{120{1'b1}}, 8'h00};
    tb_val = '0;
    bif.sys_w = 1'b0; bif.sys_r = 1'b0;
    bif.sys_w_addr = '0; bif.sys_r_addr = '0; bif.sys_w_line = '0;
    cyc(2);
    rst = 1'b0;
    cyc(1);

    chk("rst_irq", {28'h0, irq}, 32'h0);
    rd_chk("rst_out0", 32'h0A, 32'h0);
    rd_chk("rst_dir0", 32'h0B, 32'h0);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].w) wr(vecs[i].waddr, vecs[i].wdata);
      else           cyc(1);
      rd(vecs[i].raddr, v);
      if (vecs[i].expz) chk_z(vecs[i].name, v);
      else              chk(vecs[i].name, v, vecs[i].exp);
    end

    chk("pins_lo", {24'h0, pins[7:0]}, 32'h0000_00A4);
    rd_chk("p1_in", 32'h14, 32'h0);

    // read and write of the same register in one cycle returns the old value
    bif.sys_w_addr = 32'h0A; bif.sys_w_line = 32'h77; bif.sys_w = 1'b1;
    rd_chk("rd_wr_same", 32'h0A, 32'h0000_01A4);
    @(posedge clk); #1; bif.sys_w = 1'b0;
    rd_chk("rd_after_wr", 32'h0A, 32'h0000_0077);
    wr(32'h0A, 32'h0000_01A4);

    // pin32 rises right after edge t: IN at t+2, ISR and irq at t+3
    tb_val[32] = 1'b1;
    cyc(1);
    rd_chk("rise_in_t1", 32'h14, 32'h0);
    cyc(1);
    rd_chk("rise_in_t2", 32'h14, 32'h1);
    rd_chk("rise_isr_t2", 32'h17, 32'h0);
    cyc(1);
    rd_chk("rise_isr_t3", 32'h17, 32'h1);
    chk("rise_irq_t3", {31'h0, irq[1]}, 32'h1);

    // W1C landing on the same edge as a new rise keeps the bit set
    tb_val[32] = 1'b0;
    cyc(4);
    tb_val[32] = 1'b1;
    cyc(2);
    wr(32'h17, 32'h1);
    rd_chk("w1c_vs_edge", 32'h17, 32'h1);
    wr(32'h17, 32'h1);
    rd_chk("w1c_clear", 32'h17, 32'h0);
    chk("w1c_irq", {31'h0, irq[1]}, 32'h0);

    // bit1 only has FALL_EN: rise ignored, fall latched
    tb_val[33] = 1'b1;
    cyc(4);
    rd_chk("fall_on_rise", 32'h17, 32'h0);
    tb_val[33] = 1'b0;
    cyc(4);
    rd_chk("fall_isr", 32'h17, 32'h2);
    chk("fall_irq", {31'h0, irq[1]}, 32'h1);

    // enabling after the edge has passed must not set ISR
    tb_val[34] = 1'b1;
    cyc(4);
    wr(32'h15, 32'h5);
    cyc(2);
    rd_chk("late_enable", 32'h17, 32'h2);

    // loopback: a driven output pin raises its own ISR
    wr(32'h0D, 32'h1);
    wr(32'h10, 32'h1);
    cyc(3);
    rd_chk("loop_isr", 32'h0F, 32'h1);
    chk("loop_irq", {28'h0, irq}, 32'h3);

    // asynchronous reset between edges clears everything immediately
    #2 rst = 1'b1;
    #1;
    chk("arst_irq", {28'h0, irq}, 32'h0);
    checks++;
    if (!(pins[7:0] === 8'hzz || pins[7:0] === 8'h00)) begin
      errors++;
      $display("FAIL arst_pins: got %h expected z", pins[7:0]);
    end
    rd_chk("arst_out0", 32'h0A, 32'h0);
    rd_chk("arst_dir0", 32'h0B, 32'h0);
    rd_chk("arst_isr1", 32'h17, 32'h0);
    cyc(2);
    rst = 1'b0;

    // pin32 still high after release: prev=0 sees a rise, but enables are 0
    cyc(5);
    rd_chk("post_rst_isr", 32'h17, 32'h0);
    rd_chk("post_rst_in", 32'h14, 32'h0000_0005);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 Parameter N_PORTS, default 4, number of 32-pin ports; legal range 1..8.
REQ-002 Parameter BASE_ADDR, default 32'h0A, first word address of the register window.
REQ-003 Parameter SYNC_STAGES, default 2, input synchroniser depth; legal range 2..4.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 pins  inout  32*N_PORTS  device pins; port p occupies pins[32p+31:32p].
REQ-007 sys_w_addr  input  32  peripheral bus write word address.
REQ-008 sys_r_addr  input  32  peripheral bus read word address.
REQ-009 sys_w_line  input  32  write data.
REQ-010 sys_r_line  output  32  read data; shared bus, high-Z when not selected.
REQ-011 sys_w  input  1  write strobe, one write per clock while high.
REQ-012 sys_r  input  1  read strobe.
REQ-013 irq  output  N_PORTS  per-port level interrupt.

Function
REQ-014 Window = BASE_ADDR .. BASE_ADDR+8*N_PORTS-1; port p at BASE_ADDR+8p, offset k = addr-(BASE_ADDR+8p).
REQ-015 Offsets: 0 OUT (RW), 1 DIR (RW, 1=output), 2 IN (RO), 3 RISE_EN (RW), 4 FALL_EN (RW), 5 ISR (RW1C), 6 SET (WO, OUT|=data), 7 CLR (WO, OUT&=~data).
REQ-016 Writes take effect on the clk edge where sys_w=1 and sys_w_addr is in window; writes to IN or outside window ignored.
REQ-017 Read combinational: sys_r=1 and sys_r_addr in window -> sys_r_line = selected register same cycle; SET/CLR read 32'h0.
REQ-018 sys_r=0 or sys_r_addr outside window -> sys_r_line = 32'bz.
REQ-019 Pin drive: pins[i] = DIR[i] ? OUT[i] : 1'bz, per bit, combinational from registers.
REQ-020 Each pin sampled through SYNC_STAGES flops; IN = last stage; IN reflects a stable pin change SYNC_STAGES clocks later.
REQ-021 Edge detect: one extra flop holds previous IN; rise = IN & ~prev, fall = ~IN & prev.
REQ-022 ISR[i] set on the clock after IN changes when (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]); total latency pin -> ISR = SYNC_STAGES+1 clocks.
REQ-023 ISR write: bits written 1 cleared, bits written 0 unchanged.
REQ-024 Same-cycle W1C and new qualifying edge on one bit -> bit remains 1 (set wins).
REQ-025 Enables sampled in the detection cycle only; enabling after an edge does not retro-set ISR.
REQ-026 irq[p] = |ISR of port p, combinational from ISR register.
REQ-027 Output pins also feed synchroniser; edges on driven pins set ISR if enabled (loopback).
REQ-028 Simultaneous read and write of same register: read returns pre-write value.
REQ-029 SET and CLR of same bit impossible same cycle (single write port); SET/CLR do not alter DIR.

Reset
REQ-030 rst=1 asynchronously forces OUT, DIR, RISE_EN, FALL_EN, ISR, all synchroniser and prev flops to 0; all pins high-Z; irq=0.
REQ-031 rst asserted mid-operation discards pending edges; after release first possible ISR set is SYNC_STAGES+1 clocks after a qualifying pin change.
REQ-032 Rising-edge detection after reset release against a pin already high is possible (prev=0); software clears ISR before enabling — enables reset to 0 prevent spurious irq.

Verification
REQ-033 Write DIR@0x0B=0x0000_00FF, OUT@0x0A=0x0000_00A5 -> pins[7:0]=8'hA5, pins[31:8]=z; read 0x0A returns 0x0000_00A5.
REQ-034 Write SET@0x10=0x0000_0100 then CLR@0x11=0x0000_0001 -> OUT port0=0x0000_01A4; read 0x10 returns 0.
REQ-035 RISE_EN port1 (0x15)=0x1, drive pins[32] 0->1 at cycle t -> IN port1 bit0=1 at t+2, ISR@0x17=0x1 and irq[1]=1 at t+3.
REQ-036 ISR port1=0x1, write 0x17=0x1 same cycle as new qualifying edge -> ISR stays 0x1; next write 0x17=0x1 with no edge -> ISR=0, irq[1]=0.
REQ-037 Read 0x09 and 0x2A (N_PORTS=4) -> sys_r_line=z; write to 0x2A -> no register changes.
REQ-038 Assert rst mid-sequence with OUT/DIR/ISR nonzero -> all registers 0, pins z, irq=0 before next clk edge.
